// File: rtl/regfile_pkg.sv
// Shared widths and typedefs for the scoreboarded register file.
// Default build has no forwarding; define REGFILE_BYPASS_EN to add it.
package regfile_pkg;

  localparam int DFLT_DATA_PATH_WIDTH = 8;
  localparam int DFLT_ADDR_WIDTH      = 4;

  typedef logic [DFLT_ADDR_WIDTH-1:0]      reg_addr_t;
  typedef logic [DFLT_DATA_PATH_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy-bit vector with flush, pending-write counter and per-port ready lookup.
// Ports: clk, rst, wen/waddr, rsv_en/rsv_addr, flush, raddr -> rd_ready, pending_cnt.
module regfile_sb_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH     = DFLT_ADDR_WIDTH,
  parameter int NUM_READ_PORTS = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wen,
  input  logic [ADDR_WIDTH-1:0]              waddr,
  input  logic                               rsv_en,
  input  logic [ADDR_WIDTH-1:0]              rsv_addr,
  input  logic                               flush,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_READ_PORTS-1:0]          rd_ready,
  output logic [ADDR_WIDTH:0]                pending_cnt
);

  localparam int NREGS = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

  logic [NREGS-1:0]  busy_q, busy_d;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic              inc, dec;

  always_comb begin
    busy_d = busy_q;
    if (wen) busy_d[waddr] = 1'b0;
    if (flush) busy_d = '0;
    else if (rsv_en) busy_d[rsv_addr] = 1'b1;
  end

  // A 0->1 only happens on a reserve of an idle register; a 1->0 only on
  // a writeback that is not immediately re-reserved by the same cycle.
  always_comb begin
    inc   = rsv_en & ~busy_q[rsv_addr];
    dec   = wen & busy_q[waddr] & ~(rsv_en && rsv_addr == waddr);
    cnt_d = cnt_q;
    if (flush) cnt_d = '0;
    else if (inc && !dec) cnt_d = cnt_q + CNT_ONE;
    else if (dec && !inc) cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      assert (cnt_q == (ADDR_WIDTH+1)'($countones(busy_q)));
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rdy
    assign rd_ready[p] = ~busy_q[raddr[p*ADDR_WIDTH +: ADDR_WIDTH]];
  end

  assign pending_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with integrated busy-bit scoreboard.
// Ports: clk, rst, wen/waddr/data_in, rsv_en/rsv_addr, flush, raddr ->
// data_out, rd_ready, pending_cnt. Option macro: REGFILE_BYPASS_EN.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_PATH_WIDTH = DFLT_DATA_PATH_WIDTH,
  parameter int ADDR_WIDTH      = DFLT_ADDR_WIDTH,
  parameter int NUM_READ_PORTS  = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    wen,
  input  logic [ADDR_WIDTH-1:0]                   waddr,
  input  logic [DATA_PATH_WIDTH-1:0]              data_in,
  input  logic                                    rsv_en,
  input  logic [ADDR_WIDTH-1:0]                   rsv_addr,
  input  logic                                    flush,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0]    raddr,
  output logic [NUM_READ_PORTS*DATA_PATH_WIDTH-1:0] data_out,
  output logic [NUM_READ_PORTS-1:0]               rd_ready,
  output logic [ADDR_WIDTH:0]                     pending_cnt
);

  localparam int NREGS = 2**ADDR_WIDTH;

  logic [DATA_PATH_WIDTH-1:0] regs_q [NREGS];
  logic [NUM_READ_PORTS-1:0]  sb_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wen) begin
      regs_q[waddr] <= data_in;
    end
  end

  regfile_sb_scoreboard #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .NUM_READ_PORTS(NUM_READ_PORTS)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .wen        (wen),
    .waddr      (waddr),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .flush      (flush),
    .raddr      (raddr),
    .rd_ready   (sb_rdy),
    .pending_cnt(pending_cnt)
  );

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    assign a = raddr[p*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef REGFILE_BYPASS_EN
    // Forward the writeback in flight; a same-cycle reserve only takes
    // effect from the next cycle, so ready is still reported here.
    logic hit;
    assign hit = wen && (a == waddr);
    assign data_out[p*DATA_PATH_WIDTH +: DATA_PATH_WIDTH] =
      hit ? data_in : regs_q[a];
    assign rd_ready[p] = hit | sb_rdy[p];
`else
    assign data_out[p*DATA_PATH_WIDTH +: DATA_PATH_WIDTH] = regs_q[a];
    assign rd_ready[p] = sb_rdy[p];
`endif
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: driver queues expectations from a
// behavioural model, a monitor pops and compares each cycle.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int DW = DFLT_DATA_PATH_WIDTH;
  localparam int AW = DFLT_ADDR_WIDTH;
  localparam int NP = 2;
  localparam int NR = 2**AW;

  logic              clk = 1'b0;
  logic              rst, wen, rsv_en, flush;
  reg_addr_t         waddr, rsv_addr;
  reg_data_t         data_in;
  logic [NP*AW-1:0]  raddr;
  logic [NP*DW-1:0]  data_out;
  logic [NP-1:0]     rd_ready;
  logic [AW:0]       pending_cnt;

  regfile_sb #(
    .DATA_PATH_WIDTH(DW),
    .ADDR_WIDTH     (AW),
    .NUM_READ_PORTS (NP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wen        (wen),
    .waddr      (waddr),
    .data_in    (data_in),
    .rsv_en     (rsv_en),
    .rsv_addr   (rsv_addr),
    .flush      (flush),
    .raddr      (raddr),
    .data_out   (data_out),
    .rd_ready   (rd_ready),
    .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit  chk;
    int  step;
    int  d   [NP];
    bit  rdy [NP];
    int  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   step_no = 0;
  bit   done = 0;

  int   m_reg  [NR];
  bit   m_busy [NR];

  function automatic int busy_count();
    int n = 0;
    foreach (m_busy[i]) n += m_busy[i];
    return n;
  endfunction

  task automatic cyc(bit r, bit w, int wa, int wd, bit rv, int ra,
                     bit fl, int a0, int a1, bit chk = 1);
    exp_t e;
    int   ad [NP];
    @(negedge clk);
    rst = r; wen = w; waddr = AW'(wa); data_in = DW'(wd);
    rsv_en = rv; rsv_addr = AW'(ra); flush = fl;
    raddr = {AW'(a1), AW'(a0)};
    ad[0] = a0; ad[1] = a1;
    e.chk = chk; e.step = step_no; e.cnt = busy_count();
    for (int p = 0; p < NP; p++) begin
      e.d[p] = m_reg[ad[p]];
      e.rdy[p] = !m_busy[ad[p]];
`ifdef REGFILE_BYPASS_EN
      if (w && ad[p] == wa) begin
        e.d[p] = wd;
        e.rdy[p] = 1;
      end
`endif
    end
    exp_q.push_back(e);
    step_no++;
    if (r) begin
      foreach (m_reg[i]) begin m_reg[i] = 0; m_busy[i] = 0; end
    end else begin
      if (w) begin m_reg[wa] = wd; m_busy[wa] = 0; end
      if (fl) foreach (m_busy[i]) m_busy[i] = 0;
      else if (rv) m_busy[ra] = 1;
    end
  endtask

  task automatic idle(int a0, int a1);
    cyc(0, 0, 0, 0, 0, 0, 0, a0, a1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk) begin
          for (int p = 0; p < NP; p++) begin
            checks++;
            if (int'(data_out[p*DW +: DW]) != e.d[p]) begin
              failures++;
              $display("FAIL data_out[%0d] step %0d: got %0h want %0h",
                       p, e.step, data_out[p*DW +: DW], e.d[p]);
            end
            checks++;
            if (rd_ready[p] != e.rdy[p]) begin
              failures++;
              $display("FAIL rd_ready[%0d] step %0d: got %0b want %0b",
                       p, e.step, rd_ready[p], e.rdy[p]);
            end
          end
          checks++;
          if (int'(pending_cnt) != e.cnt) begin
            failures++;
            $display("FAIL pending_cnt step %0d: got %0d want %0d",
                     e.step, pending_cnt, e.cnt);
          end
        end
      end
    end
  end

  initial begin : driver
    int wa, ra, a0, a1;
    foreach (m_reg[i]) begin m_reg[i] = 0; m_busy[i] = 0; end
    // reset, then basic write/read
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 3, 'hA5, 0, 0, 0, 3, 0);
    idle(3, 0);
    // reserve then writeback
    cyc(0, 0, 0, 0, 1, 5, 0, 5, 0);
    idle(5, 3);
    cyc(0, 1, 5, 'h3C, 0, 0, 0, 5, 0);
    idle(5, 0);
    // collision on a busy register
    cyc(0, 0, 0, 0, 1, 7, 0, 7, 0);
    cyc(0, 1, 7, 'h11, 1, 7, 0, 7, 5);
    idle(7, 0);
    // flush with a same-cycle reserve
    cyc(0, 0, 0, 0, 1, 1, 0, 1, 2);
    cyc(0, 0, 0, 0, 1, 2, 0, 1, 2);
    cyc(0, 0, 0, 0, 1, 4, 0, 4, 7);
    cyc(0, 0, 0, 0, 1, 9, 1, 1, 9);
    idle(9, 4);
    // saturation
    for (int i = 0; i < NR; i++) cyc(0, 0, 0, 0, 1, i, 0, i, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 15);
    cyc(0, 1, 3, 'h42, 0, 0, 0, 3, 0);
    idle(3, 15);
    // forwarding window on a busy register
    cyc(0, 0, 0, 0, 1, 6, 1, 6, 6);
    cyc(0, 0, 0, 0, 1, 6, 0, 6, 6);
    cyc(0, 1, 6, 'h77, 1, 6, 0, 6, 3);
    idle(6, 3);
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      wa = $urandom_range(NR-1);
      ra = ($urandom_range(3) == 0) ? wa : $urandom_range(NR-1);
      a0 = ($urandom_range(2) == 0) ? wa : $urandom_range(NR-1);
      a1 = $urandom_range(NR-1);
      cyc($urandom_range(99) == 0, $urandom_range(2) == 0, wa,
          $urandom_range(255), $urandom_range(1) == 0, ra,
          $urandom_range(24) == 0, a0, a1);
    end
    idle(0, 1);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: got %0d left want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
